// File: rtl/latch_serializer_pkg.sv
// Shared state encoding and sizing helpers for the latch_serializer shift stage.
package latch_serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Counter width: one spare bit so a parity cycle at count WIDTH still fits.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/dff_ms.sv
// Master-slave bit cell: a D latch open while clk is low feeding a slave stage
// that updates on the rising edge; synchronous reset is gated into D.
module dff_ms (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic d_g;
  logic m;

  assign d_g = d & ~reset;

  // Master latch: transparent in the low phase, holds through the high phase.
  always_latch begin
    if (!clk) m <= d_g;
  end

  // Slave stage: m is frozen while clk is high, so its open phase is a copy at the rising edge.
  always_ff @(posedge clk) begin
    q <= m;
  end

endmodule

// File: rtl/latch_serializer.sv
// Parallel-in, serial-out shift stage, LSB first, with a one-cycle done pulse.
// Optional even-parity trailer bit enabled by LATCH_SERIALIZER_PARITY_EN.
module latch_serializer
  import latch_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
`ifdef LATCH_SERIALIZER_PARITY_EN
  localparam int unsigned LAST  = WIDTH;
`else
  localparam int unsigned LAST  = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             load;
  logic             last;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and load strobe; a DONE cycle may reload directly for back-to-back words.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign last = (cnt == LAST_CNT);
  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign q    = sreg;

  // Counter holds on the final shift so it never passes the last index.
  always_comb begin
    sreg_d = sreg;
    cnt_d  = cnt;
    if (load) begin
      sreg_d = data;
      cnt_d  = '0;
    end else if (busy) begin
      sreg_d = sreg >> 1;
      if (!last) cnt_d = cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_sreg
    dff_ms u_bit (.clk(clk), .reset(reset), .d(sreg_d[i]), .q(sreg[i]));
  end

  for (genvar i = 0; i < CNT_W; i++) begin : g_cnt
    dff_ms u_bit (.clk(clk), .reset(reset), .d(cnt_d[i]), .q(cnt[i]));
  end

`ifdef LATCH_SERIALIZER_PARITY_EN
  logic par;
  logic par_d;

  assign par_d = load ? ^data : par;

  dff_ms u_par (.clk(clk), .reset(reset), .d(par_d), .q(par));

  assign sout = busy & (last ? par : sreg[0]);
`else
  assign sout = busy & sreg[0];
`endif

endmodule

// File: tb/tb_latch_serializer.sv
// Scoreboard bench for latch_serializer: WIDTH=8 and WIDTH=2 instances on one clock.
module tb_latch_serializer;

`ifdef LATCH_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CNT2_MAX = 1 + PAR;

  typedef struct {
    int   cyc;
    logic b;
    logic is_done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, start2;
  logic [7:0] data8;
  logic [1:0] data2;
  logic       sout8, busy8, done8;
  logic [7:0] q8;
  logic       sout2, busy2, done2;
  logic [1:0] q2;

  exp_t q8e[$];
  exp_t q2e[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  latch_serializer #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .data(data8),
    .sout(sout8), .busy(busy8), .done(done8), .q(q8)
  );

  latch_serializer #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .data(data2),
    .sout(sout2), .busy(busy2), .done(done2), .q(q2)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_e(input int sel, input exp_t e);
    if (sel == 8) q8e.push_back(e);
    else          q2e.push_back(e);
  endtask

  // Expected stream for a word accepted at edge k: bits, optional parity, then done.
  task automatic push(input int sel, input int w, input int k, input logic [31:0] d,
                      input int nbits, input bit full);
    exp_t e;
    int   n;
    n = w;
    for (int i = 0; i < nbits; i++) begin
      e.cyc = k + i; e.b = d[i]; e.is_done = 1'b0;
      push_e(sel, e);
    end
    if (full) begin
      if (PAR != 0) begin
        e.cyc = k + w; e.b = ^d; e.is_done = 1'b0;
        push_e(sel, e);
        n = w + 1;
      end
      e.cyc = k + n; e.b = 1'b0; e.is_done = 1'b1;
      push_e(sel, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [7:0] d, input int nbits, input bit full, output int k);
    start8 = 1'b1;
    data8  = d;
    k      = cyc + 1;
    push(8, 8, k, 32'(d), nbits, full);
    tick(1);
    start8 = 1'b0;
    data8  = 8'h5A;
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (mon_en) begin
      if (busy8 || done8) begin
        if (q8e.size() == 0) begin
          tests++; fails++;
          $display("FAIL w8_unexpected: busy=%0b done=%0b with nothing pending (cycle %0d)",
                   busy8, done8, cyc);
        end else begin
          e = q8e.pop_front();
          chk("w8_cycle", cyc, e.cyc);
          chk("w8_kind", int'(done8), int'(e.is_done));
          if (!e.is_done) chk("w8_sout", int'(sout8), int'(e.b));
        end
      end else begin
        chk("w8_sout_idle", int'(sout8), 0);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (mon_en) begin
      chk("w2_cnt_bound", int'(int'(dut2.cnt) <= CNT2_MAX), 1);
      if (busy2 || done2) begin
        if (q2e.size() == 0) begin
          tests++; fails++;
          $display("FAIL w2_unexpected: busy=%0b done=%0b with nothing pending (cycle %0d)",
                   busy2, done2, cyc);
        end else begin
          e = q2e.pop_front();
          chk("w2_cycle", cyc, e.cyc);
          chk("w2_kind", int'(done2), int'(e.is_done));
          if (!e.is_done) chk("w2_sout", int'(sout2), int'(e.b));
        end
      end else begin
        chk("w2_sout_idle", int'(sout2), 0);
      end
    end
  end

  initial begin
    int k;
    int k2;
    reset  = 1'b1;
    start8 = 1'b0;
    start2 = 1'b0;
    data8  = 8'h00;
    data2  = 2'b00;
    tick(3);
    chk("rst_sout8", int'(sout8), 0);
    chk("rst_busy8", int'(busy8), 0);
    chk("rst_done8", int'(done8), 0);
    chk("rst_q8", int'(q8), 0);
    chk("rst_busy2", int'(busy2), 0);
    chk("rst_q2", int'(q2), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick(1);

    // single word 0xA5
    issue8(8'hA5, 8, 1'b1, k);
    chk("a5_load_q", int'(q8), 8'hA5);
    tick(10);
    chk("a5_q_after", int'(q8), 0);

    // start with 0x3C during the shift must be ignored
    issue8(8'hA5, 8, 1'b1, k);
    tick(3);
    start8 = 1'b1;
    data8  = 8'h3C;
    tick(1);
    start8 = 1'b0;
    tick(8);

    // back-to-back with start held high
    start8 = 1'b1;
    data8  = 8'h01;
    k      = cyc + 1;
    push(8, 8, k, 32'h01, 8, 1'b1);
    tick(1);
    data8  = 8'h80;
    k2     = k + 8 + PAR + 1;
    push(8, 8, k2, 32'h80, 8, 1'b1);
    tick(k2 - cyc);
    start8 = 1'b0;
    tick(12);

    // reset after three bits of 0xFF: no done may follow
    issue8(8'hFF, 3, 1'b0, k);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("midrst_sout", int'(sout8), 0);
    chk("midrst_busy", int'(busy8), 0);
    chk("midrst_done", int'(done8), 0);
    chk("midrst_q", int'(q8), 0);
    reset = 1'b0;
    tick(12);

    // parity vector 0x07 (odd number of ones)
    issue8(8'h07, 8, 1'b1, k);
    tick(11);

    // WIDTH=2 boundary, data 2'b10
    start2 = 1'b1;
    data2  = 2'b10;
    k      = cyc + 1;
    push(2, 2, k, 32'h2, 2, 1'b1);
    tick(1);
    start2 = 1'b0;
    data2  = 2'b01;
    chk("w2_load_q", int'(q2), 2);
    tick(6);

    chk("q8_drained", q8e.size(), 0);
    chk("q2_drained", q2e.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
